cbu_cascade_counter: RTL and testbench



---
 rtl/cbu_counter_pkg.sv | 20 ++
 rtl/cbu_cascade_counter.sv | 63 ++++++
 tb/tb_cbu_cascade_counter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cbu_counter_pkg.sv
// rtl/cbu_counter_pkg.sv - shared constants and helpers for the cbu counter macro family
package cbu_counter_pkg;

    localparam int CBU_MAX_WIDTH = 32;

    // Last value reached before the wrap to 0, expressed at the widest supported width
    function automatic logic [CBU_MAX_WIDTH-1:0] cbu_terminal_value(input longint unsigned modulus);
        longint unsigned w_term;
        w_term = modulus - 64'd1;
        return w_term[CBU_MAX_WIDTH-1:0];
    endfunction

    function automatic bit cbu_params_ok(input int width, input longint unsigned modulus);
        if (width < 1 || width > CBU_MAX_WIDTH) begin
            return 1'b0;
        end
        return (modulus >= 64'd2) && (modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/cbu_cascade_counter.sv
// rtl/cbu_cascade_counter.sv - cascadable modulo-N up counter with carry in/out
module cbu_cascade_counter
    import cbu_counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] D,
    input  logic             CAI,
    input  logic             EN,
    input  logic             PS,
    input  logic             CS,
    input  logic             LD,
    output logic [WIDTH-1:0] Q,
    output logic             CAO,
    output logic             TC
);

    localparam logic [CBU_MAX_WIDTH-1:0] TERM_FULL = cbu_terminal_value(MODULUS);
    localparam logic [WIDTH-1:0]         TERM      = TERM_FULL[WIDTH-1:0];

    if (!cbu_params_ok(WIDTH, MODULUS)) begin : g_param_error
        $fatal(1, "cbu_cascade_counter: MODULUS must lie in 2..2**WIDTH and WIDTH in 1..32");
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             w_tc;
    logic             w_count;

    // Using >= lets a verbatim out-of-range load wrap to 0 on its next count
    assign w_tc    = (r_q >= TERM);
    assign w_count = CAI & EN;

    always_comb begin
        w_next = r_q;
        if (PS) begin
            w_next = TERM;
        end else if (CS) begin
            w_next = '0;
        end else if (LD) begin
            w_next = D;
        end else if (w_count) begin
            w_next = w_tc ? '0 : r_q + WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    // Carry ignores PS/CS/LD so a chained stage sees the carry of the current count
    assign Q   = r_q;
    assign TC  = w_tc;
    assign CAO = w_count & w_tc;

endmodule

// File: tb/tb_cbu_cascade_counter.sv
// tb/tb_cbu_cascade_counter.sv - directed self-checking bench for cbu_cascade_counter
module tb_cbu_cascade_counter;

    logic       clk;
    logic       rst_n;
    int         n_checks;
    int         n_pass;

    // Binary stage, WIDTH=4 MODULUS=16
    logic [3:0] b_d;
    logic       b_cai, b_en, b_ps, b_cs, b_ld;
    logic [3:0] b_q;
    logic       b_cao, b_tc;

    // Two chained BCD stages, WIDTH=4 MODULUS=10
    logic [3:0] c0_d, c1_d;
    logic       c0_cai, c0_en, c0_ps, c0_cs, c0_ld;
    logic       c1_en, c1_ps, c1_cs, c1_ld;
    logic [3:0] c0_q, c1_q;
    logic       c0_cao, c0_tc, c1_cao, c1_tc;

    cbu_cascade_counter #(.WIDTH(4), .MODULUS(16)) u_bin (
        .CLK(clk), .RSTN(rst_n), .D(b_d), .CAI(b_cai), .EN(b_en),
        .PS(b_ps), .CS(b_cs), .LD(b_ld), .Q(b_q), .CAO(b_cao), .TC(b_tc)
    );

    cbu_cascade_counter #(.WIDTH(4), .MODULUS(10)) u_bcd0 (
        .CLK(clk), .RSTN(rst_n), .D(c0_d), .CAI(c0_cai), .EN(c0_en),
        .PS(c0_ps), .CS(c0_cs), .LD(c0_ld), .Q(c0_q), .CAO(c0_cao), .TC(c0_tc)
    );

    cbu_cascade_counter #(.WIDTH(4), .MODULUS(10)) u_bcd1 (
        .CLK(clk), .RSTN(rst_n), .D(c1_d), .CAI(c0_cao), .EN(c1_en),
        .PS(c1_ps), .CS(c1_cs), .LD(c1_ld), .Q(c1_q), .CAO(c1_cao), .TC(c1_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b_cai = 1'b1; b_en = 1'b1;
        #2;
        n_checks++;
        if (b_q !== 4'd0 || b_tc !== 1'b0 || b_cao !== 1'b0)
            $display("FAIL reset_initial: q=%0d tc=%b cao=%b expected q=0 tc=0 cao=0", b_q, b_tc, b_cao);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        b_en = 1'b0; b_ld = 1'b1; b_d = 4'd7;
        tick();
        b_ld = 1'b0;
        tick();
        n_checks++;
        if (b_q !== 4'd7) $display("FAIL reset_hold7: q=%0d expected 7", b_q);
        else n_pass++;
        b_en = 1'b1; b_ps = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (b_q !== 4'd0 || b_tc !== 1'b0 || b_cao !== 1'b0)
            $display("FAIL reset_async: q=%0d tc=%b cao=%b expected q=0 tc=0 cao=0", b_q, b_tc, b_cao);
        else n_pass++;
        tick();
        n_checks++;
        if (b_q !== 4'd0) $display("FAIL reset_held_edge: q=%0d expected 0", b_q);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; b_ps = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (b_q !== 4'd3) $display("FAIL reset_release_count: q=%0d expected 3", b_q);
        else n_pass++;
    endtask

    task automatic test_binary_wrap();
        int exp_q;
        b_cs = 1'b1;
        tick();
        b_cs = 1'b0; b_cai = 1'b1; b_en = 1'b1;
        #1;
        for (int i = 0; i <= 16; i++) begin
            exp_q = i % 16;
            n_checks++;
            if (b_q !== 4'(exp_q) || b_tc !== (exp_q == 15) || b_cao !== (exp_q == 15))
                $display("FAIL binary_wrap step %0d: q=%0d tc=%b cao=%b expected q=%0d tc=%b cao=%b",
                         i, b_q, b_tc, b_cao, exp_q, (exp_q == 15), (exp_q == 15));
            else n_pass++;
            if (i < 16) tick();
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'd15; exp_seq[1] = 4'd0; exp_seq[2] = 4'd9;
        exp_seq[3] = 4'd10; exp_seq[4] = 4'd10;
        b_ld = 1'b1; b_d = 4'd5; b_en = 1'b0;
        tick();
        n_checks++;
        if (b_q !== 4'd5) $display("FAIL priority_setup: q=%0d expected 5", b_q);
        else n_pass++;
        b_d = 4'd9; b_ps = 1'b1; b_cs = 1'b1; b_ld = 1'b1; b_en = 1'b1; b_cai = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (b_q !== exp_seq[i]) $display("FAIL priority_step %0d: q=%0d expected %0d", i, b_q, exp_seq[i]);
            else n_pass++;
            case (i)
                0: b_ps = 1'b0;
                1: b_cs = 1'b0;
                2: b_ld = 1'b0;
                3: b_en = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_bcd_cascade();
        int d0, d1, pulses, errs;
        c0_cs = 1'b1; c1_cs = 1'b1;
        tick();
        c0_cs = 1'b0; c1_cs = 1'b0;
        c0_cai = 1'b1; c0_en = 1'b1; c1_en = 1'b1;
        #1;
        d0 = 0; d1 = 0; pulses = 0; errs = 0;
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (c0_q !== 4'(d0) || c1_q !== 4'(d1) || c1_cao !== (d0 == 9 && d1 == 9)) begin
                $display("FAIL bcd_step %0d: digits=%0d%0d cao1=%b expected digits=%0d%0d cao1=%b",
                         i, c1_q, c0_q, c1_cao, d1, d0, (d0 == 9 && d1 == 9));
                errs++;
            end else n_pass++;
            if (c1_cao === 1'b1) pulses++;
            tick();
            if (d0 == 9) begin
                d0 = 0;
                d1 = (d1 == 9) ? 0 : d1 + 1;
            end else d0++;
        end
        n_checks++;
        if (c0_q !== 4'd0 || c1_q !== 4'd0 || pulses !== 1)
            $display("FAIL bcd_final: digits=%0d%0d pulses=%0d expected digits=00 pulses=1", c1_q, c0_q, pulses);
        else n_pass++;
        c1_en = 1'b0;
    endtask

    task automatic test_out_of_range_load();
        c0_cai = 1'b0; c0_en = 1'b0; c0_ld = 1'b1; c0_d = 4'd13;
        tick();
        c0_ld = 1'b0;
        n_checks++;
        if (c0_q !== 4'd13 || c0_tc !== 1'b1 || c0_cao !== 1'b0)
            $display("FAIL oor_load: q=%0d tc=%b cao=%b expected q=13 tc=1 cao=0", c0_q, c0_tc, c0_cao);
        else n_pass++;
        c0_cai = 1'b1; c0_en = 1'b1;
        #1;
        n_checks++;
        if (c0_cao !== 1'b1) $display("FAIL oor_cao: cao=%b expected 1", c0_cao);
        else n_pass++;
        tick();
        n_checks++;
        if (c0_q !== 4'd0) $display("FAIL oor_wrap: q=%0d expected 0", c0_q);
        else n_pass++;
        c0_cai = 1'b0; c0_en = 1'b0;
    endtask

    task automatic test_cao_combinational();
        logic cai_seq [4];
        cai_seq[0] = 1'b0; cai_seq[1] = 1'b1; cai_seq[2] = 1'b0; cai_seq[3] = 1'b1;
        b_ps = 1'b1; b_en = 1'b0;
        tick();
        b_ps = 1'b0; b_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_cai = cai_seq[i];
            #1;
            n_checks++;
            if (b_cao !== cai_seq[i]) $display("FAIL cao_follow %0d: cao=%b expected %b", i, b_cao, cai_seq[i]);
            else n_pass++;
        end
        b_en = 1'b0;
        #1;
        n_checks++;
        if (b_cao !== 1'b0 || b_tc !== 1'b1 || b_q !== 4'd15)
            $display("FAIL cao_en_off: cao=%b tc=%b q=%0d expected cao=0 tc=1 q=15", b_cao, b_tc, b_q);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        b_d = '0; b_cai = 1'b0; b_en = 1'b0; b_ps = 1'b0; b_cs = 1'b0; b_ld = 1'b0;
        c0_d = '0; c0_cai = 1'b0; c0_en = 1'b0; c0_ps = 1'b0; c0_cs = 1'b0; c0_ld = 1'b0;
        c1_d = '0; c1_en = 1'b0; c1_ps = 1'b0; c1_cs = 1'b0; c1_ld = 1'b0;
        test_reset();
        test_binary_wrap();
        test_priority();
        test_bcd_cascade();
        test_out_of_range_load();
        test_cao_combinational();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
